clk_share_arbiter: RTL and testbench
====================================

CLK_SHARE_ARBITER -- requirements
Module: clk_share_arbiter

Interface
REQ-001 Parameter N, default 2: number of requesters; legal range 2..8.
REQ-002 Parameter TIMEOUT, default 15: maximum grant length in cycles; legal range 1..255; used only under ARB_TIMEOUT_EN.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst  input  1  synchronous reset, active-high.
REQ-005 req  input  N  request vector; bit i high = requester i wants the shared resource.
REQ-006 gnt  output  N  registered grant; zero or one-hot.
REQ-007 gnt_valid  output  1  high when gnt is non-zero.
REQ-008 gnt_id  output  clog2(N)  index of the current owner; holds its last value when gnt_valid is low.
REQ-009 timeout  output  1  one-cycle pulse on forced revocation; constant 0 when ARB_TIMEOUT_EN is undefined.

Function
REQ-010 The block SHALL implement a three-state FSM: IDLE, GRANT and GAP.
REQ-011 In IDLE or GAP with req non-zero, the block SHALL select the first set req bit at or after round-robin pointer ptr, wrapping modulo N.
REQ-012 The block SHALL enter GRANT with gnt set to that winner on the next edge, so req-to-gnt latency is exactly 1 cycle.
REQ-013 In IDLE with req zero, the block SHALL stay in IDLE with gnt=0.
REQ-014 In GRANT, the block SHALL hold gnt and gnt_id unchanged while req[owner] stays high, regardless of any other req bits.
REQ-015 In GRANT, when req[owner] is sampled low, the block SHALL enter GAP on that edge, drive gnt=0 and set ptr=(owner+1) mod N.
REQ-016 GAP SHALL last exactly one cycle.
REQ-017 From GAP, the block SHALL go to GRANT, arbitrating per REQ-011, if req is non-zero; otherwise it SHALL go to IDLE.
REQ-018 No two requesters SHALL ever be granted in consecutive cycles; at least one gnt=0 cycle separates any two grants.
REQ-019 If the owner drops req in the same cycle another requester raises req, the block SHALL take GAP first; the new requester is served no earlier than the following edge.
REQ-020 ptr SHALL only change on leaving GRANT, so a sole requester is re-granted after every GAP.
REQ-021 gnt_valid SHALL equal the OR-reduction of gnt and be registered with it, never combinational from req.

Reset
REQ-022 While rst is high at an edge, the block SHALL set state=IDLE, gnt=0, gnt_valid=0, gnt_id=0, ptr=0, hold counter=0 and timeout=0.
REQ-023 Reset asserted mid-grant SHALL drop gnt on that same edge.
REQ-024 The first grant after reset deassertion SHALL follow REQ-011 with ptr=0.
REQ-025 rst SHALL take priority over every other transition.

Configuration
REQ-026 The feature macro SHALL be ARB_TIMEOUT_EN.
REQ-027 With ARB_TIMEOUT_EN defined, an 8-bit hold counter SHALL clear on entry to GRANT and increment in each GRANT cycle.
REQ-028 With ARB_TIMEOUT_EN defined, after TIMEOUT consecutive gnt-high cycles with req[owner] still high, the block SHALL enter GAP, drive gnt=0, pulse timeout for that one cycle and advance ptr as in REQ-015.
REQ-029 With ARB_TIMEOUT_EN undefined, no counter SHALL exist, grants SHALL be unbounded and timeout SHALL be tied to 0.

Verification (N=2, TIMEOUT=4)
REQ-030 Reset: rst=1 for 2 cycles with req=2'b11 -> gnt=00, gnt_valid=0, gnt_id=0; after rst=0, gnt=01 one cycle later.
REQ-031 Single requester: req=01 from cycle 0, dropped at cycle 5 -> gnt=01 in cycles 1..5, gnt=00 in cycle 6, and gnt stays 00 thereafter.
REQ-032 Fairness: req=11 with each owner dropping its bit for exactly one cycle after 3 grant cycles -> gnt sequence 01,01,01,00,10,10,10,00,01.
REQ-033 Timeout (macro defined): req=01 held -> gnt=01 for 4 cycles, then 00 with timeout=1 for 1 cycle, then 01 again; pattern repeats.
REQ-034 No timeout (macro undefined): req=01 held 100 cycles -> gnt=01 throughout and timeout=0.
REQ-035 Reset mid-grant: rst=1 for 1 cycle at cycle 3 of a gnt=10 grant with req=11 -> gnt=00 at that edge, then gnt=01 one cycle after rst falls (ptr=0).

Source files
------------

// File: rtl/clk_share_arbiter_if.sv
// Request/grant bundle for clk_share_arbiter.
// master: requester side (drives req, observes grant).
// slave : arbiter side (observes req, drives grant).
interface clk_share_arbiter_if #(
  parameter int N = 2
);
  logic [N-1:0]         req;
  logic [N-1:0]         gnt;
  logic                 gnt_valid;
  logic [$clog2(N)-1:0] gnt_id;
  logic                 timeout;

  modport master (output req, input gnt, gnt_valid, gnt_id, timeout);
  modport slave  (input req, output gnt, gnt_valid, gnt_id, timeout);
endinterface

// File: rtl/clk_share_arbiter.sv
// clk_share_arbiter: round-robin owner arbiter for a shared resource.
// IDLE -> GRANT (1-cycle latency) -> GAP (one idle cycle) -> GRANT/IDLE.
// The owner keeps the grant while its req stays high; the pointer moves
// past the owner only when a grant ends, so a sole requester is re-granted.
// Optional feature macro ARB_TIMEOUT_EN: bounds a grant to TIMEOUT cycles
// and pulses timeout during the forced GAP cycle.
module clk_share_arbiter #(
  parameter int N       = 2,
  parameter int TIMEOUT = 15
) (
  input logic               clk,
  input logic               rst,
  clk_share_arbiter_if.slave bus
);
  localparam int IW = $clog2(N);

  // Elaboration-time range checks.
  if (N < 2 || N > 8) begin : g_bad_n
    $error("clk_share_arbiter: N out of range 2..8");
  end
  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_to
    $error("clk_share_arbiter: TIMEOUT out of range 1..255");
  end

  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

  state_t          state_q, state_d;
  logic [N-1:0]    gnt_q, gnt_d;
  logic            gnt_valid_q;
  logic [IW-1:0]   id_q, id_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   win;
  logic [IW-1:0]   nxt_ptr;
  logic            owner_req;
`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
  logic [7:0]      cnt_q, cnt_d;
  logic            to_q, to_d;
`endif

  // First set req bit at or after ptr, wrapping modulo N.
  always_comb begin
    int  idx;
    logic found;
    win   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= N) idx = idx - N;
      if (!found && bus.req[idx]) begin
        win   = IW'(idx);
        found = 1'b1;
      end
    end
  end

  assign owner_req = bus.req[id_q];
  assign nxt_ptr   = (id_q == IW'(N - 1)) ? '0 : id_q + 1'b1;

  // Next-state and registered-output values.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    id_d    = id_q;
    ptr_d   = ptr_q;
`ifdef ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
    to_d    = 1'b0;
`endif
    unique case (state_q)
      IDLE, GAP: begin
        if (|bus.req) begin
          state_d = GRANT;
          gnt_d   = {{(N-1){1'b0}}, 1'b1} << win;
          id_d    = win;
`ifdef ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end else begin
          state_d = IDLE;
          gnt_d   = '0;
        end
      end
      GRANT: begin
        if (!owner_req) begin
          state_d = GAP;
          gnt_d   = '0;
          ptr_d   = nxt_ptr;
`ifdef ARB_TIMEOUT_EN
        end else if (cnt_q == TO_LAST) begin
          // Owner still requesting but has used its full allowance.
          state_d = GAP;
          gnt_d   = '0;
          ptr_d   = nxt_ptr;
          to_d    = 1'b1;
        end else begin
          cnt_d   = cnt_q + 8'd1;
`endif
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // State and output registers; reset wins over every transition.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      gnt_valid_q <= 1'b0;
      id_q        <= '0;
      ptr_q       <= '0;
`ifdef ARB_TIMEOUT_EN
      cnt_q       <= '0;
      to_q        <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      gnt_valid_q <= |gnt_d;
      id_q        <= id_d;
      ptr_q       <= ptr_d;
`ifdef ARB_TIMEOUT_EN
      cnt_q       <= cnt_d;
      to_q        <= to_d;
`endif
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.gnt_valid = gnt_valid_q;
  assign bus.gnt_id    = id_q;
`ifdef ARB_TIMEOUT_EN
  assign bus.timeout   = to_q;
`else
  assign bus.timeout   = 1'b0;
`endif
endmodule

// File: tb/tb_clk_share_arbiter.sv
// Bench for clk_share_arbiter (N=2, TIMEOUT=4): directed phases followed by
// random req/rst traffic; expected outputs come from a transaction-level
// owner/pointer model and are checked by an independent monitor.
module tb_clk_share_arbiter;
  localparam int N       = 2;
  localparam int TIMEOUT = 4;
  localparam int IW      = $clog2(N);
`ifdef ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  typedef struct packed {
    logic [N-1:0]  gnt;
    logic          vld;
    logic [IW-1:0] id;
    logic          to;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  clk_share_arbiter_if #(.N(N)) bus ();

  clk_share_arbiter #(.N(N), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t expq[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: who owns the resource, for how long, and where the
  // round-robin search starts next.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_run   = 0;
  int m_id    = 0;
  bit m_to    = 1'b0;

  function automatic exp_t model_step(input logic r, input logic [N-1:0] q);
    exp_t e;
    m_to = 1'b0;
    if (r) begin
      m_owner = -1; m_ptr = 0; m_run = 0; m_id = 0;
    end else if (m_owner >= 0) begin
      if (!q[m_owner] || (TO_EN && m_run == TIMEOUT)) begin
        m_to    = q[m_owner];
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
      end else begin
        m_run++;
      end
    end else if (q != '0) begin
      for (int k = N - 1; k >= 0; k--)
        if (q[(m_ptr + k) % N]) m_owner = (m_ptr + k) % N;
      m_run = 1;
      m_id  = m_owner;
    end
    e.gnt = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
    e.vld = (m_owner >= 0);
    e.id  = IW'(m_id);
    e.to  = m_to;
    return e;
  endfunction

  // Drive one cycle of stimulus and queue what the next edge must produce.
  task automatic step(input logic r, input logic [N-1:0] q);
    @(negedge clk);
    rst     = r;
    bus.req = q;
    expq.push_back(model_step(r, q));
  endtask

  // Monitor: compare DUT outputs just after every edge that has an expectation.
  initial begin
    exp_t e, a;
    forever begin
      @(posedge clk);
      #1;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        a = '{gnt: bus.gnt, vld: bus.gnt_valid, id: bus.gnt_id, to: bus.timeout};
        n_cmp++;
        if (a !== e) begin
          n_bad++;
          $display("FAIL outputs @%0t: got gnt=%b vld=%b id=%0d to=%b, want gnt=%b vld=%b id=%0d to=%b",
                   $time, a.gnt, a.vld, a.id, a.to, e.gnt, e.vld, e.id, e.to);
        end
      end
    end
  end

  initial begin
    logic [N-1:0] q;
    logic [N-1:0] fair [10];
    rst     = 1'b1;
    bus.req = '0;

    // Reset with both requesting, then release: requester 0 wins (ptr=0).
    step(1'b1, 2'b11);
    step(1'b1, 2'b11);
    for (int i = 0; i < 3; i++) step(1'b0, 2'b11);
    step(1'b0, 2'b00);
    step(1'b0, 2'b00);

    // Sole requester, dropped after five grant cycles; stays idle after.
    step(1'b1, 2'b00);
    for (int i = 0; i < 5; i++) step(1'b0, 2'b01);
    for (int i = 0; i < 4; i++) step(1'b0, 2'b00);

    // Fairness: each owner drops its bit for one cycle after three grants.
    step(1'b1, 2'b00);
    fair = '{2'b11, 2'b11, 2'b11, 2'b10, 2'b11, 2'b11, 2'b11, 2'b01, 2'b11, 2'b00};
    foreach (fair[i]) step(1'b0, fair[i]);
    step(1'b0, 2'b00);

    // Owner drops while the other raises in the same cycle: GAP first.
    step(1'b0, 2'b01);
    step(1'b0, 2'b01);
    step(1'b0, 2'b10);
    step(1'b0, 2'b10);
    step(1'b0, 2'b00);
    step(1'b0, 2'b00);

    // Reset mid-grant of requester 1, then requester 0 wins from ptr=0.
    step(1'b1, 2'b00);
    step(1'b0, 2'b01);
    step(1'b0, 2'b00);
    step(1'b0, 2'b10);
    step(1'b0, 2'b11);
    step(1'b0, 2'b11);
    step(1'b1, 2'b11);
    for (int i = 0; i < 3; i++) step(1'b0, 2'b11);
    step(1'b0, 2'b00);

    // Long hold by one requester (unbounded or periodic timeout).
    for (int i = 0; i < 100; i++) step(1'b0, 2'b01);
    step(1'b0, 2'b00);
    step(1'b0, 2'b00);

    // Random traffic with sticky requests and occasional reset.
    q = '0;
    for (int i = 0; i < 3000; i++) begin
      for (int b = 0; b < N; b++)
        if ($urandom_range(3) == 0) q[b] = ~q[b];
      step(($urandom_range(63) == 0), q);
    end

    @(posedge clk);
    #3;
    n_cmp++;
    if (expq.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, want 0", expq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
